// File: rtl/delay_masked_rmw_writer.sv
// delay_masked_rmw_writer
// Byte-masked read-modify-write engine in front of an 8 x 32-bit register
// array. After reset the array is zero-filled one entry per cycle. Only then
// are requests accepted. Each accepted request goes through three states:
// IDLE (accept), MERGE (read old word, blend bytes) and WRITE (store word,
// pulse done, bump count). A combinational read port exposes the array
// directly and does not forward pending merged data.

module delay_masked_rmw_writer (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_req_valid,
    output logic        io_req_ready,
    input  logic [31:0] io_req_addr,
    input  logic [31:0] io_req_data,
    input  logic [3:0]  io_req_mask,
    input  logic [31:0] io_rd_addr,
    output logic [31:0] io_rd_data,
    output logic        io_done,
    output logic [7:0]  io_count
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_MERGE = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    // Expand a 4-bit byte-enable into a 32-bit bit mask.
    function automatic logic [31:0] expand_mask(input logic [3:0] mask);
        logic [31:0] bits;
        bits = 32'd0;
        for (int i = 0; i < 4; i++) begin
            bits[8*i +: 8] = {8{mask[i]}};
        end
        return bits;
    endfunction

    // Take enabled bytes from new_word and all other bytes from old_word.
    function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  mask);
        logic [31:0] bits;
        bits = expand_mask(mask);
        return (new_word & bits) | (old_word & ~bits);
    endfunction

    // State and pointer registers.
    state_e      state_q,     state_d;
    logic [2:0]  clr_ptr_q,   clr_ptr_d;

    // Captured request and merge result.
    logic [2:0]  req_addr_q,  req_addr_d;
    logic [31:0] req_data_q,  req_data_d;
    logic [3:0]  req_mask_q,  req_mask_d;
    logic [31:0] merged_q,    merged_d;

    // Registered outputs.
    logic        ready_q,     ready_d;
    logic        done_q,      done_d;
    logic [7:0]  count_q,     count_d;

    // Storage array (no reset: contents are defined by the clear sweep).
    logic [31:0] mem_q [8];
    logic [31:0] mem_d [8];

    // Datapath control from the FSM.
    logic        accept_s;
    logic        wr_en_s;
    logic [2:0]  wr_addr_s;
    logic [31:0] wr_data_s;

    // Upper address bits are intentionally ignored.
    logic        unused_addr_bits_s;
    assign unused_addr_bits_s = ^{io_req_addr[31:3], io_rd_addr[31:3]};

    // Next-state logic and array write selection for each FSM state.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        accept_s  = 1'b0;
        wr_en_s   = 1'b0;
        wr_addr_s = 3'd0;
        wr_data_s = 32'd0;
        case (state_q)
            ST_CLEAR: begin
                wr_en_s   = 1'b1;
                wr_addr_s = clr_ptr_q;
                wr_data_s = 32'd0;
                clr_ptr_d = clr_ptr_q + 3'd1;
                if (clr_ptr_q == 3'd7) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_IDLE: begin
                if (io_req_valid && ready_q) begin
                    accept_s = 1'b1;
                    state_d  = ST_MERGE;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_MERGE: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                wr_en_s   = 1'b1;
                wr_addr_s = req_addr_q;
                wr_data_s = merged_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_ptr_d = 3'd0;
            end
        endcase
    end

    // Capture request fields on acceptance; hold them otherwise.
    always_comb begin
        if (accept_s) begin
            req_addr_d = io_req_addr[2:0];
            req_data_d = io_req_data;
            req_mask_d = io_req_mask;
        end else begin
            req_addr_d = req_addr_q;
            req_data_d = req_data_q;
            req_mask_d = req_mask_q;
        end
    end

    // Blend the stored word with the request bytes during MERGE.
    always_comb begin
        if (state_q == ST_MERGE) begin
            merged_d = merge_word(mem_q[req_addr_q], req_data_q, req_mask_q);
        end else begin
            merged_d = merged_q;
        end
    end

    // Output register next values: ready in IDLE, done in WRITE, count after WRITE.
    always_comb begin
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_WRITE);
        if (state_q == ST_WRITE) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Array next contents; a reset cycle suppresses any write so nothing partial lands.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_en_s && !reset) begin
            mem_d[wr_addr_s] = wr_data_s;
        end else begin
            mem_d[wr_addr_s] = mem_q[wr_addr_s];
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            clr_ptr_q  <= 3'd0;
            req_addr_q <= 3'd0;
            req_data_q <= 32'd0;
            req_mask_q <= 4'd0;
            merged_q   <= 32'd0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            req_addr_q <= req_addr_d;
            req_data_q <= req_data_d;
            req_mask_q <= req_mask_d;
            merged_q   <= merged_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            count_q    <= count_d;
        end
    end

    // Storage array update.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign io_req_ready = ready_q;
    assign io_done      = done_q;
    assign io_count     = count_q;
    assign io_rd_data   = mem_q[io_rd_addr[2:0]];

endmodule
